load_store_unit: RTL and testbench

//  MEM-stage block directly downstream of the EX adder. Consumes the adder's result as ALU result or

---
 rtl/load_store_unit_pkg.sv | 38 +++
 rtl/load_store_unit_mem_align.sv | 56 +++++
 rtl/load_store_unit.sv | 180 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared operation/exception codes and small decode helpers for the MEM-stage load/store unit.
// The EX and WB stages import the same package.
package load_store_unit_pkg;

    localparam int MEM_OP_W = 4;
    localparam int EXC_W    = 3;

    localparam logic [MEM_OP_W-1:0] MEM_OP_NONE = 4'd0;
    localparam logic [MEM_OP_W-1:0] MEM_OP_LB   = 4'd1;
    localparam logic [MEM_OP_W-1:0] MEM_OP_LBU  = 4'd2;
    localparam logic [MEM_OP_W-1:0] MEM_OP_LH   = 4'd3;
    localparam logic [MEM_OP_W-1:0] MEM_OP_LHU  = 4'd4;
    localparam logic [MEM_OP_W-1:0] MEM_OP_LW   = 4'd5;
    localparam logic [MEM_OP_W-1:0] MEM_OP_SB   = 4'd6;
    localparam logic [MEM_OP_W-1:0] MEM_OP_SH   = 4'd7;
    localparam logic [MEM_OP_W-1:0] MEM_OP_SW   = 4'd8;

    localparam logic [EXC_W-1:0] EXC_NONE = 3'd0;
    localparam logic [EXC_W-1:0] EXC_OV   = 3'd1;
    localparam logic [EXC_W-1:0] EXC_ADEL = 3'd2;
    localparam logic [EXC_W-1:0] EXC_ADES = 3'd3;
    localparam logic [EXC_W-1:0] EXC_BUS  = 3'd4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } lsu_state_e;

    // Codes 9..15 are not memory operations and pass through like NONE.
    function automatic logic is_mem_op(input logic [MEM_OP_W-1:0] op);
        return (op >= MEM_OP_LB) && (op <= MEM_OP_SW);
    endfunction

    function automatic logic is_store_op(input logic [MEM_OP_W-1:0] op);
        return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
    endfunction

endpackage

// File: rtl/load_store_unit_mem_align.sv
// Combinational lane logic: misalignment check, byte enables, store-data replication,
// and extraction plus sign/zero extension of the addressed lane of a read word.
module load_store_unit_mem_align
    import load_store_unit_pkg::*;
(
    input  logic [MEM_OP_W-1:0] op,
    input  logic [1:0]          addr_lo,
    input  logic [31:0]         store_data,
    input  logic [MEM_OP_W-1:0] ld_op,
    input  logic [1:0]          ld_addr_lo,
    input  logic [31:0]         rdata,
    output logic                misalign,
    output logic [3:0]          sel,
    output logic [31:0]         wdata,
    output logic [31:0]         load_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Loads drive the same byte enables as stores of the same size.
    always_comb begin
        misalign = 1'b0;
        sel      = 4'b1111;
        wdata    = store_data;
        case (op)
            MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: begin
                sel   = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: begin
                misalign = addr_lo[0];
                sel      = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata    = {2{store_data[15:0]}};
            end
            MEM_OP_LW, MEM_OP_SW: begin
                misalign = |addr_lo;
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte   = rdata[{ld_addr_lo, 3'b000} +: 8];
        ld_half   = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];
        load_data = rdata;
        case (ld_op)
            MEM_OP_LB:  load_data = {{24{ld_byte[7]}}, ld_byte};
            MEM_OP_LBU: load_data = {24'd0, ld_byte};
            MEM_OP_LH:  load_data = {{16{ld_half[15]}}, ld_half};
            MEM_OP_LHU: load_data = {16'd0, ld_half};
            default:    load_data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: one data-RAM transaction per load/store, upstream stall while
// the access is in flight, bus-error timeout, and a registered write-back record.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_valid,
    input  logic [MEM_OP_W-1:0] ex_mem_op,
    input  logic [31:0]         ex_result,
    input  logic                ex_overflow,
    input  logic [31:0]         ex_store_data,
    input  logic [4:0]          ex_dest,
    input  logic                ex_wb_en,
    input  logic                flush,
    output logic                ram_req,
    output logic                ram_we,
    output logic [3:0]          ram_sel,
    output logic [31:0]         ram_addr,
    output logic [31:0]         ram_wdata,
    input  logic                ram_ack,
    input  logic [31:0]         ram_rdata,
    output logic                stall_req,
    output logic                wb_valid,
    output logic                wb_we,
    output logic [4:0]          wb_dest,
    output logic [31:0]         wb_data,
    output logic [EXC_W-1:0]    exc_code,
    output logic [31:0]         exc_badvaddr,
    output lsu_state_e          dbg_state
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    lsu_state_e          state, state_next;
    logic [CNT_W-1:0]    tmo_cnt;
    logic [MEM_OP_W-1:0] op_q;
    logic [31:0]         addr_q;
    logic [4:0]          dest_q;
    logic                flushed_q;

    logic        misalign;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] load_data;

    logic accept;
    logic start_access;
    logic timeout;
    logic access_done;
    logic access_tmo;
    logic drop_wb;

    load_store_unit_mem_align u_align (
        .op         (ex_mem_op),
        .addr_lo    (ex_result[1:0]),
        .store_data (ex_store_data),
        .ld_op      (op_q),
        .ld_addr_lo (addr_q[1:0]),
        .rdata      (ram_rdata),
        .misalign   (misalign),
        .sel        (sel),
        .wdata      (wdata),
        .load_data  (load_data)
    );

    assign accept       = (state == ST_IDLE) && ex_valid && !flush;
    assign start_access = accept && !ex_overflow && !misalign && is_mem_op(ex_mem_op);
    assign timeout      = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign drop_wb      = flushed_q || flush;
    assign stall_req    = (state == ST_ACCESS);
    assign dbg_state    = state;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // RAM handshake: ram_req rises with stable addr/sel/we/wdata and stays high until the
    // cycle ram_ack is sampled; an ack in the timeout cycle completes the access normally.
    always_comb begin
        state_next  = state;
        access_done = 1'b0;
        access_tmo  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_access) state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (ram_ack) begin
                    state_next  = ST_IDLE;
                    access_done = 1'b1;
                end else if (timeout) begin
                    state_next = ST_IDLE;
                    access_tmo = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt      <= '0;
            op_q         <= MEM_OP_NONE;
            addr_q       <= '0;
            dest_q       <= '0;
            flushed_q    <= 1'b0;
            ram_req      <= 1'b0;
            ram_we       <= 1'b0;
            ram_sel      <= '0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            wb_valid     <= 1'b0;
            wb_we        <= 1'b0;
            wb_dest      <= '0;
            wb_data      <= '0;
            exc_code     <= EXC_NONE;
            exc_badvaddr <= '0;
        end else begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;

            if (accept) begin
                wb_dest      <= ex_dest;
                wb_data      <= '0;
                exc_badvaddr <= '0;
                if (ex_overflow) begin
                    wb_valid <= 1'b1;
                    exc_code <= EXC_OV;
                end else if (misalign) begin
                    wb_valid     <= 1'b1;
                    exc_code     <= is_store_op(ex_mem_op) ? EXC_ADES : EXC_ADEL;
                    exc_badvaddr <= ex_result;
                end else if (!is_mem_op(ex_mem_op)) begin
                    wb_valid <= 1'b1;
                    wb_we    <= ex_wb_en;
                    wb_data  <= ex_result;
                    exc_code <= EXC_NONE;
                end else begin
                    op_q      <= ex_mem_op;
                    addr_q    <= ex_result;
                    dest_q    <= ex_dest;
                    flushed_q <= 1'b0;
                    tmo_cnt   <= '0;
                    ram_req   <= 1'b1;
                    ram_we    <= is_store_op(ex_mem_op);
                    ram_sel   <= sel;
                    ram_addr  <= {ex_result[31:2], 2'b00};
                    ram_wdata <= wdata;
                end
            end

            if (state == ST_ACCESS) begin
                if (flush) flushed_q <= 1'b1;
                if (access_done || access_tmo) begin
                    ram_req  <= 1'b0;
                    ram_we   <= 1'b0;
                    wb_valid <= !drop_wb;
                    wb_dest  <= dest_q;
                    if (access_done) begin
                        wb_we        <= !is_store_op(op_q) && !drop_wb;
                        wb_data      <= is_store_op(op_q) ? 32'd0 : load_data;
                        exc_code     <= EXC_NONE;
                        exc_badvaddr <= '0;
                    end else begin
                        wb_data      <= '0;
                        exc_code     <= EXC_BUS;
                        exc_badvaddr <= addr_q;
                    end
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized transactions,
// with a write-back scoreboard fed by the driver and drained by an independent monitor.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    localparam int TMO = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                ex_valid;
    logic [MEM_OP_W-1:0] ex_mem_op;
    logic [31:0]         ex_result;
    logic                ex_overflow;
    logic [31:0]         ex_store_data;
    logic [4:0]          ex_dest;
    logic                ex_wb_en;
    logic                flush;
    logic                ram_req;
    logic                ram_we;
    logic [3:0]          ram_sel;
    logic [31:0]         ram_addr;
    logic [31:0]         ram_wdata;
    logic                ram_ack;
    logic [31:0]         ram_rdata;
    logic                stall_req;
    logic                wb_valid;
    logic                wb_we;
    logic [4:0]          wb_dest;
    logic [31:0]         wb_data;
    logic [EXC_W-1:0]    exc_code;
    logic [31:0]         exc_badvaddr;
    lsu_state_e          dbg_state;

    typedef struct packed {
        logic        we;
        logic [4:0]  dest;
        logic        chk_data;
        logic [31:0] data;
        logic [2:0]  exc;
        logic [31:0] badv;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_mem_op     (ex_mem_op),
        .ex_result     (ex_result),
        .ex_overflow   (ex_overflow),
        .ex_store_data (ex_store_data),
        .ex_dest       (ex_dest),
        .ex_wb_en      (ex_wb_en),
        .flush         (flush),
        .ram_req       (ram_req),
        .ram_we        (ram_we),
        .ram_sel       (ram_sel),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .ram_ack       (ram_ack),
        .ram_rdata     (ram_rdata),
        .stall_req     (stall_req),
        .wb_valid      (wb_valid),
        .wb_we         (wb_we),
        .wb_dest       (wb_dest),
        .wb_data       (wb_data),
        .exc_code      (exc_code),
        .exc_badvaddr  (exc_badvaddr),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic int op_size(input logic [MEM_OP_W-1:0] op);
        case (op)
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: return 2;
            MEM_OP_LW, MEM_OP_SW:             return 4;
            default:                          return 1;
        endcase
    endfunction

    // ---------------- driver ----------------
    // Called at a negedge with the unit idle; returns at a negedge with the unit idle.
    task automatic issue(input logic [MEM_OP_W-1:0] op, input logic [31:0] res,
                         input logic [31:0] sd, input logic [4:0] dest, input logic wb_en,
                         input logic ovf, input logic fl_in, input int wait_n,
                         input logic no_ack, input logic fl_mid, input logic [31:0] rd);
        int          size;
        int          lo;
        int          n;
        logic        is_st;
        logic        is_mem;
        logic        mis;
        logic [31:0] exp_addr;
        logic [31:0] exp_sel32;
        logic [31:0] exp_wdata;
        logic [31:0] v;
        exp_t        e;

        size   = op_size(op);
        lo     = int'(res % 4);
        is_mem = (op != MEM_OP_NONE);
        is_st  = (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
        mis    = is_mem && ((res % size) != 0);

        e      = '0;
        e.dest = dest;
        ex_valid      = 1'b1;
        ex_mem_op     = op;
        ex_result     = res;
        ex_overflow   = ovf;
        ex_store_data = sd;
        ex_dest       = dest;
        ex_wb_en      = wb_en;
        flush         = fl_in;
        if (!fl_in) begin
            if (ovf) begin
                e.exc = EXC_OV;
                exp_q.push_back(e);
            end else if (mis) begin
                e.exc  = is_st ? EXC_ADES : EXC_ADEL;
                e.badv = res;
                exp_q.push_back(e);
            end else if (!is_mem) begin
                e.we       = wb_en;
                e.chk_data = 1'b1;
                e.data     = res;
                exp_q.push_back(e);
            end
        end
        @(negedge clk);
        ex_valid = 1'b0;
        flush    = 1'b0;

        if (fl_in || ovf || mis || !is_mem) begin
            check("wb_valid_latency1", wb_valid, !fl_in);
            check("no_ram_req", ram_req, 1'b0);
            check("no_stall", stall_req, 1'b0);
            return;
        end

        exp_addr  = res - lo;
        exp_sel32 = ((32'd1 << size) - 1) << lo;
        exp_wdata = (size == 1) ? sd[7:0] * 32'h0101_0101 :
                    (size == 2) ? sd[15:0] * 32'h0001_0001 : sd;

        if (!fl_mid) begin
            if (no_ack) begin
                e.exc  = EXC_BUS;
                e.badv = res;
            end else if (!is_st) begin
                v = rd >> (8 * lo);
                if (size == 1) begin
                    v = v % 256;
                    if (op == MEM_OP_LB && v >= 128) v = v + 32'hFFFF_FF00;
                end else if (size == 2) begin
                    v = v % 65536;
                    if (op == MEM_OP_LH && v >= 32768) v = v + 32'hFFFF_0000;
                end
                e.we       = 1'b1;
                e.chk_data = 1'b1;
                e.data     = v;
            end
            exp_q.push_back(e);
        end

        flush = fl_mid;
        n     = 0;
        if (no_ack) begin
            while (ram_req && n < 20) begin
                check("acc_stall", stall_req, 1'b1);
                check("acc_addr", ram_addr, exp_addr);
                n++;
                @(negedge clk);
                flush = 1'b0;
            end
            check("timeout_req_cycles", n, TMO);
        end else begin
            for (int i = 0; i <= wait_n; i++) begin
                check("acc_req", ram_req, 1'b1);
                check("acc_stall", stall_req, 1'b1);
                check("acc_state", dbg_state, ST_ACCESS);
                check("acc_addr", ram_addr, exp_addr);
                check("acc_sel", ram_sel, exp_sel32[3:0]);
                check("acc_we", ram_we, is_st);
                if (is_st) check("acc_wdata", ram_wdata, exp_wdata);
                if (i == wait_n) begin
                    ram_ack   = 1'b1;
                    ram_rdata = rd;
                end
                @(negedge clk);
                flush     = 1'b0;
                ram_ack   = 1'b0;
                ram_rdata = $urandom;
            end
        end
        check("done_req_low", ram_req, 1'b0);
        check("done_stall_low", stall_req, 1'b0);
        check("done_wb_valid", wb_valid, !fl_mid);
    endtask

    task automatic reset_mid_access(input logic [31:0] res);
        ex_valid      = 1'b1;
        ex_mem_op     = MEM_OP_LW;
        ex_result     = res;
        ex_overflow   = 1'b0;
        ex_store_data = '0;
        ex_dest       = 5'd3;
        ex_wb_en      = 1'b1;
        @(negedge clk);
        ex_valid = 1'b0;
        check("rstmid_req_before", ram_req, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_req", ram_req, 1'b0);
        check("rstmid_wb_valid", wb_valid, 1'b0);
        check("rstmid_stall", stall_req, 1'b0);
        rst = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst && wb_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wb_unexpected actual=valid expected=none dest=%0d", wb_dest);
            end else begin
                mon_e = exp_q.pop_front();
                check("wb_we", wb_we, mon_e.we);
                check("wb_dest", wb_dest, mon_e.dest);
                check("exc_code", exc_code, mon_e.exc);
                check("exc_badvaddr", exc_badvaddr, mon_e.badv);
                if (mon_e.chk_data) check("wb_data", wb_data, mon_e.data);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        ex_valid = 1'b0; ex_mem_op = MEM_OP_NONE; ex_result = '0; ex_overflow = 1'b0;
        ex_store_data = '0; ex_dest = '0; ex_wb_en = 1'b0; flush = 1'b0;
        ram_ack = 1'b0; ram_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst_ram_req", ram_req, 1'b0);
        check("rst_stall", stall_req, 1'b0);
        check("rst_wb_valid", wb_valid, 1'b0);
        check("rst_wb_we", wb_we, 1'b0);
        check("rst_ram_addr", ram_addr, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_exc_code", exc_code, EXC_NONE);
        check("rst_state", dbg_state, ST_IDLE);
        rst = 1'b0;
        @(negedge clk);

        issue(MEM_OP_NONE, 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 32'h0);
        issue(MEM_OP_NONE, 32'hDEAD_BEEF, 32'h0, 5'd9, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 32'h0);
        issue(MEM_OP_LB, 32'h103, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b0, 32'h80FF_0000);
        issue(MEM_OP_SH, 32'h202, 32'hABCD, 5'd0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 32'h0);
        issue(MEM_OP_LW, 32'h101, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 32'h0);
        issue(MEM_OP_LW, 32'h101, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 32'h0);
        issue(MEM_OP_SW, 32'h300, 32'h5555_AAAA, 5'd0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 32'h0);
        reset_mid_access(32'h500);
        issue(MEM_OP_LW, 32'h400, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b1, 32'h1111_2222);
        issue(MEM_OP_LW, 32'h404, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0, 32'h0);
        issue(MEM_OP_LHU, 32'h602, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 32'h9876_5432);
        issue(MEM_OP_LH, 32'h602, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0, 32'h9876_5432);
        issue(MEM_OP_SB, 32'h701, 32'h0000_00C3, 5'd0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 32'h0);
        issue(MEM_OP_SH, 32'h703, 32'h1234, 5'd0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 32'h0);

        for (int t = 0; t < 300; t++) begin
            issue(MEM_OP_W'($urandom_range(0, 8)), $urandom, $urandom, 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 15) == 0), $urandom_range(0, 3),
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0), $urandom);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
